// File: rtl/rs_bank.sv
// Reservation-station bank: lowest-free issue, CDB operand capture with issue
// bypass, and lowest-index-ready dispatch. One rs_entry instance per slot.

module rs_entry #(
   parameter int DATA_W = 16,
   parameter int TAG_W  = 4,
   parameter int OP_W   = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              issue_we_i,
   input  logic [OP_W-1:0]   issue_op_i,
   input  logic [DATA_W-1:0] issue_vj_i,
   input  logic [TAG_W-1:0]  issue_qj_i,
   input  logic [DATA_W-1:0] issue_vk_i,
   input  logic [TAG_W-1:0]  issue_qk_i,
   input  logic              cdb_valid_i,
   input  logic [TAG_W-1:0]  cdb_tag_i,
   input  logic [DATA_W-1:0] cdb_data_i,
   input  logic              disp_clr_i,
   output logic              busy_o,
   output logic [OP_W-1:0]   op_o,
   output logic [DATA_W-1:0] vj_o,
   output logic [DATA_W-1:0] vk_o,
   output logic              ready_o
);

   logic              busy_q, busy_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic [DATA_W-1:0] vj_q, vj_d, vk_q, vk_d;
   logic [TAG_W-1:0]  qj_q, qj_d, qk_q, qk_d;
   logic              cdb_hit;

   assign cdb_hit = cdb_valid_i && (cdb_tag_i != '0);

   always_comb begin
      busy_d = busy_q;
      op_d   = op_q;
      vj_d   = vj_q;
      qj_d   = qj_q;
      vk_d   = vk_q;
      qk_d   = qk_q;
      // A freeing entry ignores the CDB; it is never the issue target in the same cycle.
      if (disp_clr_i) begin
         busy_d = 1'b0;
      end else if (issue_we_i) begin
         busy_d = 1'b1;
         op_d   = issue_op_i;
         if (cdb_hit && (issue_qj_i == cdb_tag_i)) begin
            vj_d = cdb_data_i;
            qj_d = '0;
         end else begin
            vj_d = issue_vj_i;
            qj_d = issue_qj_i;
         end
         if (cdb_hit && (issue_qk_i == cdb_tag_i)) begin
            vk_d = cdb_data_i;
            qk_d = '0;
         end else begin
            vk_d = issue_vk_i;
            qk_d = issue_qk_i;
         end
      end else if (busy_q) begin
         if (cdb_hit && (qj_q == cdb_tag_i)) begin
            vj_d = cdb_data_i;
            qj_d = '0;
         end
         if (cdb_hit && (qk_q == cdb_tag_i)) begin
            vk_d = cdb_data_i;
            qk_d = '0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         busy_q <= 1'b0;
         op_q   <= '0;
         vj_q   <= '0;
         qj_q   <= '0;
         vk_q   <= '0;
         qk_q   <= '0;
      end else begin
         busy_q <= busy_d;
         op_q   <= op_d;
         vj_q   <= vj_d;
         qj_q   <= qj_d;
         vk_q   <= vk_d;
         qk_q   <= qk_d;
      end
   end

   assign busy_o  = busy_q;
   assign op_o    = op_q;
   assign vj_o    = vj_q;
   assign vk_o    = vk_q;
   assign ready_o = busy_q && (qj_q == '0) && (qk_q == '0);

endmodule

module rs_bank #(
   parameter int ENTRIES = 4,
   parameter int DATA_W  = 16,
   parameter int TAG_W   = 4,
   parameter int OP_W    = 4,
   parameter int RS_BASE = 1
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         issue_valid,
   output logic                         issue_ready,
   input  logic [OP_W-1:0]              issue_op,
   input  logic [DATA_W-1:0]            issue_vj,
   input  logic [DATA_W-1:0]            issue_vk,
   input  logic [TAG_W-1:0]             issue_qj,
   input  logic [TAG_W-1:0]             issue_qk,
   output logic [TAG_W-1:0]             issue_tag,
   input  logic                         cdb_valid,
   input  logic [TAG_W-1:0]             cdb_tag,
   input  logic [DATA_W-1:0]            cdb_data,
   output logic                         disp_valid,
   input  logic                         disp_ready,
   output logic [OP_W-1:0]              disp_op,
   output logic [DATA_W-1:0]            disp_a,
   output logic [DATA_W-1:0]            disp_b,
   output logic [TAG_W-1:0]             disp_tag,
   output logic [$clog2(ENTRIES+1)-1:0] count
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int CNT_W = $clog2(ENTRIES+1);

   logic [ENTRIES-1:0]             e_busy, e_ready, e_we, e_clr;
   logic [ENTRIES-1:0][OP_W-1:0]   e_op;
   logic [ENTRIES-1:0][DATA_W-1:0] e_vj, e_vk;
   logic [IDX_W-1:0]               free_idx, disp_idx;
   logic                           issue_fire, disp_fire;
   logic [CNT_W-1:0]               count_q, count_d;

   // Both selections come from registered state only, so neither handshake
   // depends combinationally on the other or on the CDB.
   always_comb begin
      free_idx = '0;
      disp_idx = '0;
      for (int i = ENTRIES-1; i >= 0; i--) begin
         if (!e_busy[i])  free_idx = IDX_W'(i);
         if (e_ready[i])  disp_idx = IDX_W'(i);
      end
   end

   assign issue_ready = ~&e_busy;
   assign issue_tag   = TAG_W'(RS_BASE) + TAG_W'(free_idx);
   assign disp_valid  = |e_ready;
   assign issue_fire  = issue_valid && issue_ready;
   assign disp_fire   = disp_valid && disp_ready;

   always_comb begin
      disp_op  = '0;
      disp_a   = '0;
      disp_b   = '0;
      disp_tag = '0;
      if (disp_valid) begin
         disp_op  = e_op[disp_idx];
         disp_a   = e_vj[disp_idx];
         disp_b   = e_vk[disp_idx];
         disp_tag = TAG_W'(RS_BASE) + TAG_W'(disp_idx);
      end
   end

   genvar g;
   generate
      for (g = 0; g < ENTRIES; g++) begin : g_ent
         assign e_we[g]  = issue_fire && (free_idx == IDX_W'(g));
         assign e_clr[g] = disp_fire && (disp_idx == IDX_W'(g));
         rs_entry #(.DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W)) u_ent (
            .clock       (clock),
            .reset       (reset),
            .issue_we_i  (e_we[g]),
            .issue_op_i  (issue_op),
            .issue_vj_i  (issue_vj),
            .issue_qj_i  (issue_qj),
            .issue_vk_i  (issue_vk),
            .issue_qk_i  (issue_qk),
            .cdb_valid_i (cdb_valid),
            .cdb_tag_i   (cdb_tag),
            .cdb_data_i  (cdb_data),
            .disp_clr_i  (e_clr[g]),
            .busy_o      (e_busy[g]),
            .op_o        (e_op[g]),
            .vj_o        (e_vj[g]),
            .vk_o        (e_vk[g]),
            .ready_o     (e_ready[g])
         );
      end
   endgenerate

   always_comb begin
      count_d = count_q;
      case ({issue_fire, disp_fire})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: tb/tb_rs_bank.sv
// Directed bench for rs_bank at default parameters (4 entries, tags 1..4).

module tb_rs_bank;

   logic        clock = 1'b0;
   logic        reset;
   logic        issue_valid, issue_ready;
   logic [3:0]  issue_op;
   logic [15:0] issue_vj, issue_vk;
   logic [3:0]  issue_qj, issue_qk, issue_tag;
   logic        cdb_valid;
   logic [3:0]  cdb_tag;
   logic [15:0] cdb_data;
   logic        disp_valid, disp_ready;
   logic [3:0]  disp_op;
   logic [15:0] disp_a, disp_b;
   logic [3:0]  disp_tag;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   rs_bank dut (
      .clock(clock), .reset(reset),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
      .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_qj(issue_qj), .issue_qk(issue_qk),
      .issue_tag(issue_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
      .disp_a(disp_a), .disp_b(disp_b), .disp_tag(disp_tag), .count(count)
   );

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_issue(input logic [3:0] op, input logic [15:0] vj, input logic [3:0] qj,
                           input logic [15:0] vk, input logic [3:0] qk);
      issue_op = op; issue_vj = vj; issue_qj = qj; issue_vk = vk; issue_qk = qk;
      issue_valid = 1'b1;
      step();
      issue_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL rst_issue_ready got %0b exp 1", issue_ready); end
      checks++; if (issue_tag !== 4'd1) begin errors++; $display("FAIL rst_issue_tag got %0d exp 1", issue_tag); end
      checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL rst_disp_valid got %0b exp 0", disp_valid); end
      checks++; if ({disp_op, disp_a, disp_b, disp_tag} !== 40'd0) begin errors++;
         $display("FAIL rst_disp_zero got op=%0h a=%0h b=%0h tag=%0h exp all 0", disp_op, disp_a, disp_b, disp_tag); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", count); end
   endtask

   task automatic test_basic();
      disp_ready = 1'b1;
      do_issue(4'd3, 16'd5, 4'd0, 16'd7, 4'd0);
      checks++; if (disp_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b exp 1", disp_valid); end
      checks++; if (disp_tag !== 4'd1) begin errors++; $display("FAIL basic_tag got %0d exp 1", disp_tag); end
      checks++; if (disp_a !== 16'd5 || disp_b !== 16'd7 || disp_op !== 4'd3) begin errors++;
         $display("FAIL basic_data got op=%0d a=%0d b=%0d exp op=3 a=5 b=7", disp_op, disp_a, disp_b); end
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL basic_count1 got %0d exp 1", count); end
      step();
      checks++; if (count !== 3'd0 || disp_valid !== 1'b0) begin errors++;
         $display("FAIL basic_drain got count=%0d valid=%0b exp 0/0", count, disp_valid); end
      disp_ready = 1'b0;
   endtask

   task automatic test_cdb_capture();
      do_issue(4'd1, 16'h0000, 4'd9, 16'd2, 4'd0);
      cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_data = 16'h1234;
      checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL cap_during_cdb got %0b exp 0", disp_valid); end
      step();
      cdb_valid = 1'b0;
      checks++; if (disp_valid !== 1'b1 || disp_a !== 16'h1234 || disp_b !== 16'd2) begin errors++;
         $display("FAIL cap_after got valid=%0b a=%0h b=%0h exp 1/1234/2", disp_valid, disp_a, disp_b); end
      disp_ready = 1'b1; step(); disp_ready = 1'b0;
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL cap_count got %0d exp 0", count); end
   endtask

   task automatic test_bypass();
      issue_op = 4'd2; issue_vj = 16'h0; issue_qj = 4'd6; issue_vk = 16'h0042; issue_qk = 4'd0;
      issue_valid = 1'b1;
      cdb_valid = 1'b1; cdb_tag = 4'd6; cdb_data = 16'hBEEF;
      step();
      issue_valid = 1'b0; cdb_valid = 1'b0;
      checks++; if (disp_valid !== 1'b1 || disp_a !== 16'hBEEF || disp_b !== 16'h0042) begin errors++;
         $display("FAIL bypass got valid=%0b a=%0h b=%0h exp 1/beef/42", disp_valid, disp_a, disp_b); end
      disp_ready = 1'b1; step(); disp_ready = 1'b0;
      // Tag-0 broadcast must not touch an operand already present.
      do_issue(4'd4, 16'h0011, 4'd0, 16'h0000, 4'd4);
      cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_data = 16'hFFFF;
      step();
      cdb_tag = 4'd4; cdb_data = 16'h0022;
      step();
      cdb_valid = 1'b0;
      checks++; if (disp_valid !== 1'b1 || disp_a !== 16'h0011 || disp_b !== 16'h0022) begin errors++;
         $display("FAIL tag0_ignore got valid=%0b a=%0h b=%0h exp 1/11/22", disp_valid, disp_a, disp_b); end
      do_reset();
   endtask

   task automatic test_full();
      for (int i = 0; i < 4; i++) do_issue(4'd5, 16'(16'h100 + i), 4'd0, 16'd0, 4'd0);
      checks++; if (issue_ready !== 1'b0 || count !== 3'd4) begin errors++;
         $display("FAIL full_state got ready=%0b count=%0d exp 0/4", issue_ready, count); end
      do_issue(4'd9, 16'hDEAD, 4'd0, 16'hDEAD, 4'd0);
      checks++; if (count !== 3'd4 || disp_a !== 16'h0100 || disp_op !== 4'd5) begin errors++;
         $display("FAIL full_ignore got count=%0d a=%0h op=%0d exp 4/100/5", count, disp_a, disp_op); end
      disp_ready = 1'b1; step(); disp_ready = 1'b0;
      checks++; if (issue_ready !== 1'b1 || issue_tag !== 4'd1 || count !== 3'd3) begin errors++;
         $display("FAIL full_free got ready=%0b tag=%0d count=%0d exp 1/1/3", issue_ready, issue_tag, count); end
      checks++; if (disp_tag !== 4'd2 || disp_a !== 16'h0101) begin errors++;
         $display("FAIL full_next got tag=%0d a=%0h exp 2/101", disp_tag, disp_a); end
      // Concurrent issue into entry 0 and dispatch of entry 1.
      issue_op = 4'd6; issue_vj = 16'h0AAA; issue_qj = 4'd0; issue_vk = 16'h0; issue_qk = 4'd0;
      issue_valid = 1'b1; disp_ready = 1'b1;
      step();
      issue_valid = 1'b0; disp_ready = 1'b0;
      checks++; if (count !== 3'd3 || issue_tag !== 4'd2) begin errors++;
         $display("FAIL both_count got count=%0d issue_tag=%0d exp 3/2", count, issue_tag); end
      checks++; if (disp_tag !== 4'd1 || disp_a !== 16'h0AAA) begin errors++;
         $display("FAIL both_disp got tag=%0d a=%0h exp 1/aaa", disp_tag, disp_a); end
      do_reset();
   endtask

   task automatic test_order();
      do_issue(4'd1, 16'h000A, 4'd0, 16'd0, 4'd0);
      do_issue(4'd2, 16'h0000, 4'd7, 16'd0, 4'd0);
      do_issue(4'd3, 16'h000C, 4'd0, 16'd0, 4'd0);
      checks++; if (disp_tag !== 4'd1 || disp_a !== 16'h000A) begin errors++;
         $display("FAIL order_first got tag=%0d a=%0h exp 1/a", disp_tag, disp_a); end
      disp_ready = 1'b1; step();
      checks++; if (disp_tag !== 4'd3 || disp_a !== 16'h000C) begin errors++;
         $display("FAIL order_second got tag=%0d a=%0h exp 3/c", disp_tag, disp_a); end
      step(); disp_ready = 1'b0;
      checks++; if (disp_valid !== 1'b0 || count !== 3'd1) begin errors++;
         $display("FAIL order_wait got valid=%0b count=%0d exp 0/1", disp_valid, count); end
      cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_data = 16'h0077;
      step();
      cdb_valid = 1'b0;
      checks++; if (disp_tag !== 4'd2 || disp_a !== 16'h0077 || disp_op !== 4'd2) begin errors++;
         $display("FAIL order_late got tag=%0d a=%0h op=%0d exp 2/77/2", disp_tag, disp_a, disp_op); end
      disp_ready = 1'b1; step(); disp_ready = 1'b0;
      checks++; if (count !== 3'd0 || disp_valid !== 1'b0) begin errors++;
         $display("FAIL order_drain got count=%0d valid=%0b exp 0/0", count, disp_valid); end
   endtask

   task automatic test_reset_flush();
      for (int i = 0; i < 3; i++) do_issue(4'd7, 16'd0, 4'd8, 16'd1, 4'd0);
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_fill got %0d exp 3", count); end
      reset = 1'b1; issue_valid = 1'b1; disp_ready = 1'b1;
      cdb_valid = 1'b1; cdb_tag = 4'd8; cdb_data = 16'h5555;
      step();
      reset = 1'b0; issue_valid = 1'b0; disp_ready = 1'b0; cdb_valid = 1'b0;
      checks++; if (count !== 3'd0 || disp_valid !== 1'b0) begin errors++;
         $display("FAIL flush_state got count=%0d valid=%0b exp 0/0", count, disp_valid); end
      checks++; if (issue_ready !== 1'b1 || issue_tag !== 4'd1 || disp_a !== 16'd0) begin errors++;
         $display("FAIL flush_free got ready=%0b tag=%0d a=%0h exp 1/1/0", issue_ready, issue_tag, disp_a); end
   endtask

   initial begin
      reset = 1'b1; issue_valid = 1'b0; issue_op = '0; issue_vj = '0; issue_vk = '0;
      issue_qj = '0; issue_qk = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
      disp_ready = 1'b0;
      test_reset();
      test_basic();
      test_cdb_capture();
      test_bypass();
      test_full();
      test_order();
      test_reset_flush();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rs_bank.md
RS_BANK -- requirements
Module: rs_bank

Interface
- REQ-001 SHALL have parameter ENTRIES, default 4, number of reservation-station entries (2..16).
- REQ-002 SHALL have parameter DATA_W, default 16, operand/result width.
- REQ-003 SHALL have parameter TAG_W, default 4, producer-tag width; tag 0 means "value present, no producer".
- REQ-004 SHALL have parameter OP_W, default 4, opcode width.
- REQ-005 SHALL have parameter RS_BASE, default 1, tag of entry 0; entry i owns tag RS_BASE+i; RS_BASE>=1 and RS_BASE+ENTRIES-1 <= 2^TAG_W-1.
- REQ-006 SHALL have port clock, input, 1, rising-edge clock.
- REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
- REQ-008 SHALL have ports issue_valid (in, 1) and issue_ready (out, 1), the issue handshake.
- REQ-009 SHALL have port issue_op, input, OP_W, the opcode.
- REQ-010 SHALL have ports issue_vj and issue_vk, input, DATA_W each, the operand values.
- REQ-011 SHALL have ports issue_qj and issue_qk, input, TAG_W each, the operand producer tags.
- REQ-012 SHALL have port issue_tag, output, TAG_W, the tag the next accepted issue will own.
- REQ-013 SHALL have ports cdb_valid (in, 1), cdb_tag (in, TAG_W) and cdb_data (in, DATA_W), the common-data-bus broadcast.
- REQ-014 SHALL have ports disp_valid (out, 1) and disp_ready (in, 1), the dispatch handshake.
- REQ-015 SHALL have ports disp_op (out, OP_W), disp_a and disp_b (out, DATA_W each) and disp_tag (out, TAG_W), the dispatched instruction.
- REQ-016 SHALL have port count, output, clog2(ENTRIES+1), number of busy entries.

Function
- REQ-017 Each entry SHALL hold busy, op, vj, qj, vk, qk.
- REQ-018 issue_ready SHALL be 1 iff at least one entry is not busy, computed from registered state only.
- REQ-019 issue_tag SHALL be RS_BASE plus the lowest free index; value is don't-care when issue_ready=0.
- REQ-020 On issue_valid & issue_ready, the lowest free entry SHALL become busy at the next edge and latch op, vj/qj and vk/qk.
- REQ-021 Issue bypass: if cdb_valid and cdb_tag equals a nonzero issue_qj (or qk) in the issue cycle, the entry SHALL latch cdb_data as the operand value with q=0.
- REQ-022 Capture: every busy entry with qj (or qk) equal to cdb_tag, when cdb_valid and cdb_tag != 0, SHALL latch cdb_data into vj (or vk) and clear the q field; qj and qk SHALL both capture when both match.
- REQ-023 cdb_tag=0 with cdb_valid SHALL be ignored.
- REQ-024 An entry is ready when busy and qj=0 and qk=0, evaluated on registered state; a CDB capture makes it ready one cycle after the broadcast edge.
- REQ-025 disp_valid SHALL be 1 iff any entry is ready; the selected entry is the lowest-index ready entry.
- REQ-026 disp_op, disp_a=vj, disp_b=vk and disp_tag=RS_BASE+index SHALL come from the selected entry combinationally; they are 0 when disp_valid=0.
- REQ-027 On disp_valid & disp_ready, the selected entry SHALL clear busy at the next edge.
- REQ-028 While disp_ready=0, disp outputs SHALL remain stable unless a lower-index entry becomes ready.
- REQ-029 Simultaneous issue and dispatch SHALL both complete; a freed entry is not reissued in the same cycle, and count is unchanged.
- REQ-030 count SHALL increment on issue, decrement on dispatch, and hold when both occur; it never exceeds ENTRIES.
- REQ-031 issue_valid while full SHALL be ignored with no state change.
- REQ-032 A CDB broadcast in the issue cycle SHALL not capture into the entry being freed in the same cycle.

Reset
- REQ-033 On reset=1 at an edge, all busy bits, op, v and q fields, and count SHALL be 0.
- REQ-034 After reset, issue_ready=1, issue_tag=RS_BASE, disp_valid=0, and disp_op, disp_a, disp_b and disp_tag are 0.
- REQ-035 Reset SHALL override concurrent issue, dispatch and CDB activity, and SHALL flush entries mid-operation.

Verification (defaults)
- REQ-036 Issue op=3, vj=5, qj=0, vk=7, qk=0 with disp_ready=1 -> next cycle disp_valid=1, disp_tag=1, a=5, b=7; the cycle after, count=0.
- REQ-037 Issue qj=9, vk=2, qk=0; no dispatch; then CDB tag=9, data=0x1234 -> disp_valid=0 during the CDB cycle and 1 one cycle later with a=0x1234.
- REQ-038 Issue with qj=6 while cdb_valid, tag=6, data=0xBEEF in the same cycle -> entry ready next cycle with a=0xBEEF.
- REQ-039 Issue 4 entries with disp_ready=0 -> issue_ready=0, count=4; a 5th issue_valid is ignored; one dispatch -> issue_ready=1 and issue_tag equals the freed tag.
- REQ-040 Entries 0 and 2 ready, entry 1 waiting -> dispatch order is tag 1 then tag 3; entry 1 is captured later and then dispatches.
- REQ-041 Fill 3 entries, assert reset for 1 cycle with cdb_valid=1 -> count=0, disp_valid=0, and no entry captured.
